// File: rtl/isa_pkg.sv
// isa_pkg: opcode map, flag encodings and sequencer state shared by the core
package isa_pkg;
    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_NOT  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_CMP  = 5'b01000;
    localparam logic [4:0] OP_MOV  = 5'b01001;
    localparam logic [4:0] OP_LDR  = 5'b01010;
    localparam logic [4:0] OP_LDI  = 5'b01011;
    localparam logic [4:0] OP_STR  = 5'b01100;
    localparam logic [4:0] OP_STI  = 5'b01101;
    localparam logic [4:0] OP_INC  = 5'b01110;
    localparam logic [4:0] OP_DEC  = 5'b01111;
    localparam logic [4:0] OP_ADDI = 5'b10000;
    localparam logic [4:0] OP_SUBI = 5'b10001;
    localparam logic [4:0] OP_CMPI = 5'b10010;
    localparam logic [4:0] OP_JMP  = 5'b10011;
    localparam logic [4:0] OP_JNE  = 5'b10100;
    localparam logic [4:0] OP_JEQ  = 5'b10101;
    localparam logic [4:0] OP_MULT = 5'b10110;
    localparam logic [4:0] OP_NOP  = 5'b10111;

    localparam logic [1:0] FLAG_NONE = 2'b00;
    localparam logic [1:0] FLAG_EQ   = 2'b01;
    localparam logic [1:0] FLAG_GT   = 2'b10;

    typedef enum logic [2:0] {
        RUN,
        MUL_EXE,
        MUL_WB_LO,
        MUL_WB_HI,
        LD_WAIT,
        BR_FLUSH
    } seq_state_t;
endpackage

// File: rtl/exec_sequencer_if.sv
// exec_sequencer_if: decode-side inputs and pipeline/PC controls of the sequencer
interface exec_sequencer_if #(parameter int CNT_W = 16);
    logic             id_valid;
    logic [4:0]       opcode;
    logic [1:0]       flags;
    logic             pc_en;
    logic             pc_load;
    logic             id_hold;
    logic             flush;
    logic             mul_start;
    logic             wb_en;
    logic             wb_hi_sel;
    logic             busy;
    logic [CNT_W-1:0] retired;

    modport master (
        output id_valid, opcode, flags,
        input  pc_en, pc_load, id_hold, flush, mul_start, wb_en, wb_hi_sel, busy, retired
    );
    modport slave (
        input  id_valid, opcode, flags,
        output pc_en, pc_load, id_hold, flush, mul_start, wb_en, wb_hi_sel, busy, retired
    );
endinterface

// File: rtl/seq_down_counter.sv
// seq_down_counter: loadable 4-bit down-counter that saturates at zero
module seq_down_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] ld_val,
    output logic       zero
);
    logic [3:0] cnt;

    // load has priority; otherwise count down and hold at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= ld_val;
        else if (cnt != 4'd0) cnt <= cnt - 4'd1;
    end

    assign zero = cnt == 4'd0;
endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer: stalls the pipeline for multiply/load, resolves jumps, counts retires
module exec_sequencer
    import isa_pkg::*;
#(
    parameter int MUL_LAT     = 4,
    parameter int LD_LAT      = 2,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 16
) (
    input logic               clk,
    input logic               rst_n,
    exec_sequencer_if.slave   bus
);
    // Wait states cover LAT-1 cycles after the issue cycle in RUN, so the counter
    // starts at LAT-2 and the wait state is skipped entirely when LAT is 1.
    localparam logic [3:0] MUL_LD   = 4'(MUL_LAT > 1 ? MUL_LAT - 2 : 0);
    localparam logic [3:0] LD_LD    = 4'(LD_LAT > 1 ? LD_LAT - 2 : 0);
    localparam logic [3:0] FLUSH_LD = 4'(FLUSH_DEPTH > 1 ? FLUSH_DEPTH - 2 : 0);

    seq_state_t       state;
    logic [CNT_W-1:0] retired_q;
    logic             zero;
    logic             run, is_mul, is_ld, taken, retire;
    logic             pc_en_c, id_hold_c, flush_c;
    logic [3:0]       ld_val;

    seq_down_counter u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (run),
        .ld_val (ld_val),
        .zero   (zero)
    );

    // decode the instruction in RUN and derive the per-state control levels
    always_comb begin
        run    = state == RUN;
        is_mul = bus.id_valid && bus.opcode == OP_MULT;
        is_ld  = bus.id_valid && (bus.opcode == OP_LDR || bus.opcode == OP_LDI);
        taken  = bus.id_valid && (bus.opcode == OP_JMP ||
                 (bus.opcode == OP_JEQ && bus.flags == FLAG_EQ) ||
                 (bus.opcode == OP_JNE && (bus.flags == FLAG_NONE || bus.flags == FLAG_GT)));
        ld_val = is_mul ? MUL_LD : is_ld ? LD_LD : FLUSH_LD;
        retire = (run && bus.id_valid && !is_mul && !(is_ld && LD_LAT > 1) && bus.opcode != OP_NOP)
                 || state == MUL_WB_HI || (state == LD_WAIT && zero);
        pc_en_c   = run ? !(is_mul || is_ld || taken) : state == BR_FLUSH;
        id_hold_c = run ? (is_mul || is_ld) : state != BR_FLUSH;
        flush_c   = run ? taken : state == BR_FLUSH;
    end

    // sequencer state and retired-instruction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            retired_q <= '0;
        end else begin
            retired_q <= retired_q + CNT_W'(retire);
            case (state)
                RUN:       state <= is_mul ? (MUL_LAT > 1 ? MUL_EXE : MUL_WB_LO)
                                  : is_ld ? (LD_LAT > 1 ? LD_WAIT : RUN)
                                  : taken ? (FLUSH_DEPTH > 1 ? BR_FLUSH : RUN) : RUN;
                MUL_EXE:   state <= zero ? MUL_WB_LO : MUL_EXE;
                MUL_WB_LO: state <= MUL_WB_HI;
                MUL_WB_HI: state <= RUN;
                LD_WAIT:   state <= zero ? RUN : LD_WAIT;
                BR_FLUSH:  state <= zero ? RUN : BR_FLUSH;
                default:   state <= RUN;
            endcase
        end
    end

    // outputs are forced low while reset is asserted
    assign bus.pc_en     = rst_n && pc_en_c;
    assign bus.pc_load   = rst_n && run && taken;
    assign bus.id_hold   = rst_n && id_hold_c;
    assign bus.flush     = rst_n && flush_c;
    assign bus.mul_start = rst_n && run && is_mul;
    assign bus.wb_en     = rst_n && (state == MUL_WB_LO || state == MUL_WB_HI);
    assign bus.wb_hi_sel = rst_n && state == MUL_WB_HI;
    assign bus.busy      = rst_n && !run;
    assign bus.retired   = retired_q;
endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: directed checks of stalls, jumps, reset and retire counting
module tb_exec_sequencer;
    import isa_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    exec_sequencer_if #(.CNT_W(16)) bus ();

    exec_sequencer #(.MUL_LAT(4), .LD_LAT(2), .FLUSH_DEPTH(2), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // bit order: pc_en pc_load id_hold flush mul_start wb_en wb_hi_sel busy
    localparam logic [7:0] O_IDLE  = 8'b1000_0000;
    localparam logic [7:0] O_ZERO  = 8'b0000_0000;
    localparam logic [7:0] O_MULI  = 8'b0010_1000;
    localparam logic [7:0] O_MULX  = 8'b0010_0001;
    localparam logic [7:0] O_WBLO  = 8'b0010_0101;
    localparam logic [7:0] O_WBHI  = 8'b0010_0111;
    localparam logic [7:0] O_JTAKE = 8'b0101_0000;
    localparam logic [7:0] O_FLUSH = 8'b1001_0001;
    localparam logic [7:0] O_LDI   = 8'b0010_0000;
    localparam logic [7:0] O_LDW   = 8'b0010_0001;

    function automatic logic [7:0] outs();
        return {bus.pc_en, bus.pc_load, bus.id_hold, bus.flush,
                bus.mul_start, bus.wb_en, bus.wb_hi_sel, bus.busy};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // drive one cycle of decode inputs, check outputs at the falling edge
    task automatic cyc(input logic v, input logic [4:0] op, input logic [1:0] f,
                       input logic [7:0] exp, input string tag);
        bus.id_valid = v;
        bus.opcode   = op;
        bus.flags    = f;
        @(negedge clk);
        check(tag, 32'(outs()), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.id_valid = 1'b1;
        bus.opcode   = OP_MULT;
        bus.flags    = FLAG_NONE;
        @(negedge clk);
        check("reset_outs", 32'(outs()), 32'(O_ZERO));
        check("reset_ret", 32'(bus.retired), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b0, OP_ADD, FLAG_NONE, O_IDLE, "post_reset_idle");

        cyc(1'b1, OP_MULT, FLAG_NONE, O_MULI, "mul_c0");
        cyc(1'b1, OP_JMP, FLAG_NONE, O_MULX, "mul_c1_jmp_ignored");
        cyc(1'b0, OP_ADD, FLAG_NONE, O_MULX, "mul_c2");
        cyc(1'b0, OP_ADD, FLAG_NONE, O_MULX, "mul_c3");
        check("mul_ret_pending", 32'(bus.retired), 32'd0);
        cyc(1'b0, OP_ADD, FLAG_NONE, O_WBLO, "mul_c4_wblo");
        cyc(1'b0, OP_ADD, FLAG_NONE, O_WBHI, "mul_c5_wbhi");
        check("mul_ret", 32'(bus.retired), 32'd1);
        cyc(1'b0, OP_ADD, FLAG_NONE, O_IDLE, "mul_c6_run");

        cyc(1'b1, OP_JEQ, FLAG_EQ, O_JTAKE, "jeq_eq_issue");
        check("jeq_eq_ret", 32'(bus.retired), 32'd2);
        cyc(1'b1, OP_JMP, FLAG_NONE, O_FLUSH, "jeq_eq_flush2");
        cyc(1'b0, OP_ADD, FLAG_NONE, O_IDLE, "jeq_eq_done");

        cyc(1'b1, OP_JEQ, FLAG_NONE, O_IDLE, "jeq_ne_not_taken");
        check("jeq_ne_ret", 32'(bus.retired), 32'd3);

        cyc(1'b1, OP_JNE, FLAG_GT, O_JTAKE, "jne_gt_issue");
        cyc(1'b0, OP_ADD, FLAG_NONE, O_FLUSH, "jne_gt_flush2");
        check("jne_gt_ret", 32'(bus.retired), 32'd4);
        cyc(1'b1, OP_JNE, FLAG_EQ, O_IDLE, "jne_eq_not_taken");
        check("jne_eq_ret", 32'(bus.retired), 32'd5);

        cyc(1'b1, OP_LDI, FLAG_NONE, O_LDI, "ldi_issue");
        check("ldi_ret_pending", 32'(bus.retired), 32'd5);
        cyc(1'b0, OP_ADD, FLAG_NONE, O_LDW, "ldi_wait");
        check("ldi_ret", 32'(bus.retired), 32'd6);
        cyc(1'b0, OP_ADD, FLAG_NONE, O_IDLE, "ldi_done");
        cyc(1'b1, OP_LDR, FLAG_NONE, O_LDI, "ldr_issue");
        cyc(1'b0, OP_ADD, FLAG_NONE, O_LDW, "ldr_wait");
        check("ldr_ret", 32'(bus.retired), 32'd7);

        for (int i = 0; i < 5; i++) cyc(1'b1, OP_ADD, FLAG_NONE, O_IDLE, "add_stream");
        cyc(1'b1, OP_NOP, FLAG_NONE, O_IDLE, "nop");
        check("stream_ret", 32'(bus.retired), 32'd12);
        cyc(1'b1, 5'b11111, FLAG_NONE, O_IDLE, "undefined_op");
        check("undef_ret", 32'(bus.retired), 32'd13);

        cyc(1'b1, OP_MULT, FLAG_NONE, O_MULI, "abort_mul_c0");
        cyc(1'b0, OP_ADD, FLAG_NONE, O_MULX, "abort_mul_c1");
        rst_n = 1'b0;
        #1;
        check("abort_outs", 32'(outs()), 32'(O_ZERO));
        check("abort_ret", 32'(bus.retired), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b0, OP_ADD, FLAG_NONE, O_IDLE, "abort_recover_idle");
        cyc(1'b0, OP_ADD, FLAG_NONE, O_IDLE, "abort_recover_idle2");
        check("abort_recover_ret", 32'(bus.retired), 32'd0);

        bus.id_valid = 1'b1;
        bus.opcode   = OP_ADD;
        repeat (65535) @(posedge clk);
        #1;
        check("wrap_max", 32'(bus.retired), 32'h0000_FFFF);
        @(posedge clk);
        #1;
        check("wrap_zero", 32'(bus.retired), 32'd0);
        bus.id_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
